// File: rtl/trig_phase_quadrant_gen.sv
// Phase stage of the trig functional-link expansion: steps k = 1..NUM_HARM per sample and folds k*pi*x into a quarter-wave index plus swap/sign/zero flags.
// Optional build macro TRIG_PHASE_ROUND_EN selects round-to-nearest phase quantisation instead of truncation.
module trig_phase_quadrant_gen #(
  parameter int NUM_HARM = 4,
  parameter int IN_W     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] x_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_idx,
  output logic            out_swap,
  output logic            out_sin_neg,
  output logic            out_cos_neg,
  output logic            out_sin_zero,
  output logic            out_cos_zero,
  output logic [3:0]      out_harm,
  output logic            out_last,
  output logic            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready and the beat fields hold steady until that transfer.

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [3:0] LAST_K = 4'(NUM_HARM);

  logic [0:0]      state;
  logic [IN_W-1:0] x_reg;
  logic [IN_W-1:0] acc;
  logic [3:0]      k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      x_reg <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_reg <= x_in;
            acc   <= x_in;
            k     <= 4'd1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            if (k == LAST_K) begin
              state <= S_IDLE;
            end else begin
              // Accumulating x gives k*x mod 2^IN_W, i.e. k*pi*x mod 2*pi.
              acc <= acc + x_reg;
              k   <= k + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic       running;
  logic [7:0] ph8;
  logic [1:0] quad;
  logic [5:0] r;
  logic       swap;
  logic       sin_neg;
  logic       cos_neg;

  always_comb begin
    running = (state == S_RUN);
`ifdef TRIG_PHASE_ROUND_EN
    // Adding half an LSB of ph8 below the cut is the same as carrying in the next bit down.
    ph8 = acc[IN_W-1 -: 8] + {7'b0, acc[IN_W-9]};
`else
    ph8 = acc[IN_W-1 -: 8];
`endif
    quad    = ph8[7:6];
    r       = ph8[5:0];
    swap    = quad[0];
    sin_neg = quad[1];
    cos_neg = quad[1] ^ quad[0];
  end

  // Fields are forced to zero outside RUN so reset and idle present a clean bus.
  always_comb begin
    in_ready     = (state == S_IDLE) & ~rst;
    out_valid    = running;
    out_idx      = running ? {1'b0, r} : 7'd0;
    out_swap     = running & swap;
    out_sin_neg  = running & sin_neg;
    out_cos_neg  = running & cos_neg;
    out_sin_zero = running & (r == 6'd0) & ~swap;
    out_cos_zero = running & (r == 6'd0) & swap;
    out_harm     = running ? k : 4'd0;
    out_last     = running & (k == LAST_K);
    dbg_state    = state[0];
  end

endmodule

// File: tb/tb_trig_phase_quadrant_gen.sv
// Bench for trig_phase_quadrant_gen: directed vector table, hand-written handshake/reset sequences
// and randomized traffic scored against an arithmetic phase model.
module tb_trig_phase_quadrant_gen;

  localparam int NUM_HARM = 4;
  localparam int IN_W     = 16;
  localparam int W        = 17;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] x_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [6:0]      out_idx;
  logic            out_swap, out_sin_neg, out_cos_neg, out_sin_zero, out_cos_zero;
  logic [3:0]      out_harm;
  logic            out_last;
  logic            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  trig_phase_quadrant_gen #(.NUM_HARM(NUM_HARM), .IN_W(IN_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_swap(out_swap),
    .out_sin_neg(out_sin_neg), .out_cos_neg(out_cos_neg), .out_sin_zero(out_sin_zero),
    .out_cos_zero(out_cos_zero), .out_harm(out_harm), .out_last(out_last), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: phase k*pi*x quantised to 256 steps per turn, then quadrant/remainder.
  function automatic logic [W-1:0] model(input logic [15:0] x, input int k);
    int unsigned ph, p8, quadrant, rem;
    logic sw, sn, cn, sz, cz, last;
    ph = (k * int'(x)) % 65536;
`ifdef TRIG_PHASE_ROUND_EN
    p8 = ((ph + 128) / 256) % 256;
`else
    p8 = ph / 256;
`endif
    quadrant = p8 / 64;
    rem      = p8 % 64;
    sw   = (quadrant % 2) == 1;
    sn   = quadrant >= 2;
    cn   = (quadrant == 1) || (quadrant == 2);
    sz   = (rem == 0) && !sw;
    cz   = (rem == 0) && sw;
    last = (k == NUM_HARM);
    return {last, 4'(k), cz, sz, cn, sn, sw, 7'(rem)};
  endfunction

  function automatic logic [W-1:0] dut_beat();
    return {out_last, out_harm, out_cos_zero, out_sin_zero, out_cos_neg, out_sin_neg, out_swap, out_idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic issue(input logic [15:0] x);
    int n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready stayed 0, expected 1");
    end
    in_valid = 1'b1;
    x_in     = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_beat(output logic [W-1:0] b);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 40) begin tick(); n++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL beat_timeout: out_valid stayed 0, expected 1");
    end
    b = dut_beat();
    tick();
  endtask

  typedef struct {
    logic [15:0] x;
    int          k;
    logic [6:0]  idx;
    logic        swap, sn, cn, sz, cz;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [W-1:0] b, prev;
    logic prev_stall;
    int exp_h, accepted, cyc;
    logic pat [6];

    vecs.push_back('{16'h2000, 1, 7'd32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h2000, 2, 7'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h2000, 3, 7'd32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h2000, 4, 7'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{16'hE000, 1, 7'd32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h1000, 1, 7'd16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 1, 7'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 1, 7'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
`ifdef TRIG_PHASE_ROUND_EN
    vecs.push_back('{16'h7FFF, 2, 7'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h00C0, 1, 7'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
`else
    vecs.push_back('{16'h7FFF, 2, 7'd63, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h00C0, 1, 7'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`endif

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_fields", 32'(dut_beat()), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // directed table
    foreach (vecs[i]) begin
      issue(vecs[i].x);
      for (int kk = 1; kk <= NUM_HARM; kk++) begin
        get_beat(b);
        if (kk == vecs[i].k)
          check($sformatf("vec%0d_x%h_k%0d", i, vecs[i].x, kk), 32'(b),
                32'({vecs[i].k == NUM_HARM, 4'(vecs[i].k), vecs[i].cz, vecs[i].sz,
                     vecs[i].cn, vecs[i].sn, vecs[i].swap, vecs[i].idx}));
      end
    end
    out_ready = 1'b0;
    tick();

    // backpressure 1,0,0,1,1,1
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    issue(16'h2000);
    exp_h = 1;
    prev_stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 6; c++) begin
      out_ready = pat[c];
      check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
      if (prev_stall) check($sformatf("bp_frozen_c%0d", c), 32'(dut_beat()), 32'(prev));
      if (out_ready) begin
        check($sformatf("bp_beat_c%0d", c), 32'(dut_beat()), 32'(model(16'h2000, exp_h)));
        exp_h++;
      end
      prev_stall = out_valid & ~out_ready;
      prev = dut_beat();
      tick();
    end
    out_ready = 1'b0;
    check("bp_done_out_valid", 32'(out_valid), 32'd0);
    check("bp_done_in_ready", 32'(in_ready), 32'd1);

    // reset mid-run at k = 2
    issue(16'h2000);
    get_beat(b);
    out_ready = 1'b0;
    check("mid_rst_at_k2", 32'(out_harm), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_fields", 32'(dut_beat()), 32'd0);
    issue(16'h2000);
    get_beat(b);
    check("mid_rst_restart", 32'(b), 32'(model(16'h2000, 1)));
    for (int kk = 2; kk <= NUM_HARM; kk++) get_beat(b);

    // in_valid held during RUN must not be latched
    out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    x_in = 16'h2000;
    tick();
    x_in = 16'h1000;
    for (int kk = 1; kk <= NUM_HARM; kk++) begin
      get_beat(b);
      check($sformatf("hold_valid_k%0d", kk), 32'(b), 32'(model(16'h2000, kk)));
    end
    out_ready = 1'b0;
    check("hold_valid_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    get_beat(b);
    check("hold_valid_second_k1", 32'(b), 32'(model(16'h1000, 1)));
    for (int kk = 2; kk <= NUM_HARM; kk++) get_beat(b);

    // randomized traffic against the model
    accepted = 0;
    cyc = 0;
    prev_stall = 1'b0;
    while ((accepted < 40 || exp_q.size() != 0) && cyc < 5000) begin
      in_valid  = (accepted < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      x_in      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) check("rnd_frozen", 32'(dut_beat()), 32'(prev));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_unexpected_beat: got 0x%0h, expected no beat", dut_beat());
        end else begin
          check("rnd_beat", 32'(dut_beat()), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        for (int kk = 1; kk <= NUM_HARM; kk++) exp_q.push_back(model(x_in, kk));
        accepted++;
      end
      prev_stall = out_valid & ~out_ready;
      prev = dut_beat();
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_samples_accepted", 32'(accepted), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
